// File: rtl/branch_pkg.sv
// Shared encodings, state/flag enums and the branch offset table for branch_ctrl.
package branch_pkg;

  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [4:0] OP_BLT  = 5'b11100;
  localparam logic [4:0] OP_BNE  = 5'b11101;
  localparam logic [8:0] OP_HALT = 9'h1FF;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef enum logic [1:0] {EQ = 2'b00, LT = 2'b01, GT = 2'b10} flag_t;

  // Signed PC offsets selected by instr[3:0] of a branch.
  localparam logic [7:0] BR_LUT [16] = '{
    8'h02, 8'hFD, 8'h04, 8'hFC, 8'h08, 8'hF8, 8'h10, 8'hF0,
    8'h01, 8'hFF, 8'h06, 8'hFA, 8'h20, 8'hE0, 8'h7F, 8'h80
  };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch offset lookup.
module branch_lut
  import branch_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] offset
);

  assign offset = BR_LUT[idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch/compare control: IDLE/RUN/HALTED FSM, registered compare flag,
// same-cycle branch resolution and a saturating taken-branch counter.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] instr,
  output logic [2:0] ra_addr,
  output logic [2:0] rb_addr,
  input  logic [7:0] ra_val,
  input  logic [7:0] rb_val,
  output logic       branch_sig,
  output logic       branch_type,
  output logic       take,
  output logic [7:0] branch_offset,
  output logic       halt,
  output logic       done,
  output logic [7:0] taken_cnt
);

  state_t     state, state_n;
  flag_t      flag, flag_n;
  logic [7:0] cnt_n;
  logic [7:0] lut_off;
  logic       is_cmp, is_blt, is_bne, is_halt;

  assign ra_addr = instr[5:3];
  assign rb_addr = instr[2:0];

  assign is_cmp  = instr[8:6] == OP_CMP;
  assign is_blt  = instr[8:4] == OP_BLT;
  assign is_bne  = instr[8:4] == OP_BNE;
  assign is_halt = instr == OP_HALT;

  assign halt = state != RUN;
  assign done = state == HALTED;

  branch_lut u_lut (
    .idx    (instr[3:0]),
    .offset (lut_off)
  );

  always_comb begin
    state_n       = state;
    flag_n        = flag;
    cnt_n         = taken_cnt;
    branch_sig    = 1'b0;
    branch_type   = 1'b0;
    take          = 1'b0;
    branch_offset = 8'h00;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        if (is_halt) state_n = HALTED;
        if (is_cmp) begin
          if ($signed(ra_val) < $signed(rb_val))      flag_n = LT;
          else if ($signed(ra_val) > $signed(rb_val)) flag_n = GT;
          else                                        flag_n = EQ;
        end
        // Branches resolve against the flag as registered, never this cycle's CMP.
        if (is_blt || is_bne) begin
          branch_sig    = 1'b1;
          branch_type   = instr[4];
          branch_offset = lut_off;
          take          = is_blt ? (flag == LT) : (flag != EQ);
        end
        if (branch_sig && take && taken_cnt != 8'hFF) cnt_n = taken_cnt + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      flag      <= EQ;
      taken_cnt <= 8'h00;
    end else begin
      state     <= state_n;
      flag      <= flag_n;
      taken_cnt <= cnt_n;
    end
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock shared with the fetch unit
- reset  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that releases the CPU from IDLE
- instr  in  9  instruction word at the current fetch address
- ra_addr  out  3  register-file read address A = instr[5:3]
- rb_addr  out  3  register-file read address B = instr[2:0]
- ra_val  in  8  register-file read data A (combinational)
- rb_val  in  8  register-file read data B (combinational)
- branch_sig  out  1  current instruction is a branch and the block is in RUN
- branch_type  out  1  0 = BLT, 1 = BNE
- take  out  1  branch condition holds; fetch SHALL redirect when branch_sig & take
- branch_offset  out  8  signed PC offset; fetch adds it modulo 256
- halt  out  1  fetch SHALL hold the PC
- done  out  1  HALT instruction retired
- taken_cnt  out  8  number of taken branches, saturating

Function
REQ-003 Decode SHALL use these encodings:
- CMP = instr[8:6]==3'b110
- BLT = instr[8:4]==5'b11100
- BNE = instr[8:4]==5'b11101
- HALT = instr==9'h1FF
- anything else = non-control
REQ-004 The FSM SHALL have three states, IDLE, RUN and HALTED, with these transitions:
- IDLE→RUN on start==1
- RUN→HALTED on HALT decoded
- HALTED is exited only by reset
REQ-005 start SHALL be ignored in RUN and in HALTED.
REQ-006 halt SHALL equal 1 in IDLE and in HALTED, and 0 in RUN (combinational from state).
REQ-007 done SHALL be 1 only in HALTED.
REQ-008 In RUN, a CMP SHALL register the 2-bit flag at the next posedge from a signed compare of ra_val and rb_val: EQ=2'b00, LT=2'b01, GT=2'b10.
REQ-009 The flag SHALL change only on CMP in RUN.
REQ-010 Outside RUN, or for a non-branch instruction, branch_sig SHALL be 0 and take SHALL be 0.
REQ-011 For a branch in RUN, outputs SHALL be combinational in the same cycle:
- branch_sig=1
- branch_type=instr[4]
- branch_offset=LUT[instr[3:0]]
REQ-012 take SHALL be (flag==LT) for BLT and (flag!=EQ) for BNE, using the registered flag, so a CMP influences only later instructions.
REQ-013 taken_cnt SHALL increment at the posedge ending each cycle with branch_sig & take, and SHALL saturate at 8'hFF.
REQ-014 branch_offset SHALL be 8'h00 whenever branch_sig==0.
REQ-015 ra_addr and rb_addr SHALL always reflect instr fields, independent of state.
REQ-016 HALT decoded in IDLE SHALL be ignored; only RUN acts on instructions.

Reset
REQ-017 While reset==0 at a posedge, the block SHALL load: state=IDLE, flag=EQ, taken_cnt=0.
REQ-018 The resulting outputs SHALL be: halt=1, done=0, branch_sig=0, take=0, branch_offset=0.
REQ-019 Reset asserted mid-RUN or in HALTED SHALL take priority over start, CMP and HALT in the same cycle.

Structure
REQ-020 A shared package branch_pkg SHALL hold:
- opcode constants
- the flag enum (EQ/LT/GT)
- the state enum (IDLE/RUN/HALTED)
- the 16-entry 8-bit LUT constant, with LUT[0]=8'h02, LUT[1]=8'hFD, LUT[15]=8'h80
REQ-021 The LUT lookup SHALL be a separate combinational sub-module, branch_lut (4-bit index in, 8-bit offset out).

Verification
REQ-022 Reset then start: reset=0 for 2 cycles, then release, then start=1 for 1 cycle → halt=1 and done=0 before start; halt=0 from the cycle after start.
REQ-023 BLT taken: CMP with ra_val=8'hFE, rb_val=8'h01 (signed -2 < 1), then BLT idx 1 → branch_sig=1, take=1, branch_offset=8'hFD, taken_cnt=1.
REQ-024 BNE not taken: CMP with ra_val=8'h05, rb_val=8'h05, then BNE idx 0 → take=0, branch_offset=8'h02, taken_cnt unchanged.
REQ-025 HALT: instr=9'h1FF in RUN → halt=1 and done=1 next cycle; a later start pulse keeps HALTED and branch_sig stays 0.
REQ-026 Saturation: 300 taken BNE cycles with flag=GT → taken_cnt stops at 8'hFF.
REQ-027 Reset mid-RUN: reset=0 in the same cycle as a CMP with LT operands → flag=EQ, state=IDLE, taken_cnt=0.
